// File: rtl/dmaio_if.sv
// CPU register-port and initiator-bus signals of the dmaio byte-copy DMA engine.
// The slave modport is the engine's view; master is the system/top-level view.
interface dmaio_if;
    logic        cs;
    logic        rw;
    logic [2:0]  AD;
    logic [7:0]  DI;
    logic [7:0]  DO;
    logic        m_own;
    logic [15:0] m_AD;
    logic [7:0]  m_DO;
    logic [7:0]  m_DI;
    logic        m_rw;
    logic        m_vma;

    modport master (
        output cs, rw, AD, DI, m_DI,
        input  DO, m_own, m_AD, m_DO, m_rw, m_vma
    );

    modport slave (
        input  cs, rw, AD, DI, m_DI,
        output DO, m_own, m_AD, m_DO, m_rw, m_vma
    );
endinterface

// File: rtl/dmaio.sv
// Byte-copy DMA engine: eight CPU-visible registers plus a bus-initiator FSM that
// holds the CPU, copies CNT bytes SRC->DST in 3-cycle RD/RDW/WR steps, then releases.
module dmaio #(
    parameter int unsigned HOLD_WAIT = 2
) (
    input  logic     clk,
    input  logic     rst,
    dmaio_if.slave   bus,
    output logic     irq,
    output logic     hold
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RD   = 3'd2,
        S_RDW  = 3'd3,
        S_WR   = 3'd4
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(HOLD_WAIT - 1);

    state_t      state_q, state_d;
    logic [15:0] src_q, src_d;
    logic [15:0] dst_q, dst_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ie_q, ie_d;
    logic        src_fix_q, src_fix_d;
    logic        dst_fix_q, dst_fix_d;
    logic        done_q, done_d;
    logic        aborted_q, aborted_d;
    logic        abort_pend_q, abort_pend_d;
    logic [3:0]  wait_q, wait_d;
    logic [7:0]  buf_q, buf_d;
    logic        irq_q, irq_d;
    logic        hold_q, hold_d;
    logic        m_own_q, m_own_d;
    logic [15:0] m_ad_q, m_ad_d;
    logic [7:0]  m_do_q, m_do_d;
    logic        m_rw_q, m_rw_d;
    logic        m_vma_q, m_vma_d;

    logic        busy_s;
    logic        wr_s;
    logic        ctrl_wr_s;
    logic        start_s;
    logic        abort_s;
    logic        stat_rd_s;
    logic [7:0]  do_s;

    assign busy_s    = (state_q != S_IDLE);
    assign wr_s      = bus.cs & ~bus.rw;
    assign ctrl_wr_s = wr_s & (bus.AD == 3'd6);
    assign start_s   = ctrl_wr_s & bus.DI[0];
    assign abort_s   = ctrl_wr_s & bus.DI[7];
    assign stat_rd_s = bus.cs & bus.rw & (bus.AD == 3'd7);

    // Next-state logic: register writes, FSM sequencing and the registered bus outputs
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        cnt_d        = cnt_q;
        ie_d         = ie_q;
        src_fix_d    = src_fix_q;
        dst_fix_d    = dst_fix_q;
        done_d       = done_q;
        aborted_d    = aborted_q;
        abort_pend_d = abort_pend_q;
        wait_d       = wait_q;
        buf_d        = buf_q;

        if (!busy_s && wr_s) begin
            case (bus.AD)
                3'd0:    src_d[15:8] = bus.DI;
                3'd1:    src_d[7:0]  = bus.DI;
                3'd2:    dst_d[15:8] = bus.DI;
                3'd3:    dst_d[7:0]  = bus.DI;
                3'd4:    cnt_d[15:8] = bus.DI;
                3'd5:    cnt_d[7:0]  = bus.DI;
                3'd6: begin
                    ie_d      = bus.DI[1];
                    src_fix_d = bus.DI[2];
                    dst_fix_d = bus.DI[3];
                end
                default: ;
            endcase
        end else begin
            state_d = state_q;
        end

        if (stat_rd_s) begin
            done_d    = 1'b0;
            aborted_d = 1'b0;
        end else begin
            done_d = done_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start_s) begin
                    aborted_d = 1'b0;
                    if (cnt_q != 16'd0) begin
                        state_d = S_REQ;
                        done_d  = 1'b0;
                        wait_d  = WAIT_INIT;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    abort_pend_d = 1'b0;
                end
            end
            S_REQ: begin
                if (abort_s) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (wait_q == 4'd0) begin
                    state_d = S_RD;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_RD: begin
                if (abort_s) begin
                    abort_pend_d = 1'b1;
                end else begin
                    abort_pend_d = abort_pend_q;
                end
                state_d = S_RDW;
            end
            S_RDW: begin
                if (abort_s) begin
                    abort_pend_d = 1'b1;
                end else begin
                    abort_pend_d = abort_pend_q;
                end
                buf_d   = bus.m_DI;
                state_d = S_WR;
            end
            S_WR: begin
                if (!src_fix_q) begin
                    src_d = src_q + 16'd1;
                end else begin
                    src_d = src_q;
                end
                if (!dst_fix_q) begin
                    dst_d = dst_q + 16'd1;
                end else begin
                    dst_d = dst_q;
                end
                cnt_d = cnt_q - 16'd1;
                // An ABORT written during this very WR cycle still stops after this byte
                if ((cnt_d == 16'd0) || abort_pend_q || abort_s) begin
                    state_d      = S_IDLE;
                    done_d       = 1'b1;
                    aborted_d    = abort_pend_q | abort_s;
                    abort_pend_d = 1'b0;
                end else begin
                    state_d = S_RD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        hold_d  = (state_d != S_IDLE);
        m_own_d = (state_d == S_RD) || (state_d == S_RDW) || (state_d == S_WR);
        m_vma_d = (state_d == S_RD) || (state_d == S_WR);
        m_rw_d  = (state_d != S_WR);
        case (state_d)
            S_RD, S_RDW: begin
                m_ad_d = src_d;
                m_do_d = 8'h00;
            end
            S_WR: begin
                m_ad_d = dst_d;
                m_do_d = buf_d;
            end
            default: begin
                m_ad_d = 16'h0000;
                m_do_d = 8'h00;
            end
        endcase
        irq_d = done_d & ie_d;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            src_q        <= 16'h0000;
            dst_q        <= 16'h0000;
            cnt_q        <= 16'h0000;
            ie_q         <= 1'b0;
            src_fix_q    <= 1'b0;
            dst_fix_q    <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
            abort_pend_q <= 1'b0;
            wait_q       <= 4'd0;
            buf_q        <= 8'h00;
            irq_q        <= 1'b0;
            hold_q       <= 1'b0;
            m_own_q      <= 1'b0;
            m_ad_q       <= 16'h0000;
            m_do_q       <= 8'h00;
            m_rw_q       <= 1'b1;
            m_vma_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            cnt_q        <= cnt_d;
            ie_q         <= ie_d;
            src_fix_q    <= src_fix_d;
            dst_fix_q    <= dst_fix_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
            abort_pend_q <= abort_pend_d;
            wait_q       <= wait_d;
            buf_q        <= buf_d;
            irq_q        <= irq_d;
            hold_q       <= hold_d;
            m_own_q      <= m_own_d;
            m_ad_q       <= m_ad_d;
            m_do_q       <= m_do_d;
            m_rw_q       <= m_rw_d;
            m_vma_q      <= m_vma_d;
        end
    end

    // Register read mux, combinational from AD
    always_comb begin
        case (bus.AD)
            3'd0:    do_s = src_q[15:8];
            3'd1:    do_s = src_q[7:0];
            3'd2:    do_s = dst_q[15:8];
            3'd3:    do_s = dst_q[7:0];
            3'd4:    do_s = cnt_q[15:8];
            3'd5:    do_s = cnt_q[7:0];
            3'd6:    do_s = {4'b0000, dst_fix_q, src_fix_q, ie_q, 1'b0};
            3'd7:    do_s = {5'b00000, aborted_q, done_q, busy_s};
            default: do_s = 8'h00;
        endcase
    end

    assign bus.DO    = do_s;
    assign bus.m_own = m_own_q;
    assign bus.m_AD  = m_ad_q;
    assign bus.m_DO  = m_do_q;
    assign bus.m_rw  = m_rw_q;
    assign bus.m_vma = m_vma_q;
    assign irq       = irq_q;
    assign hold      = hold_q;

endmodule

// File: tb/tb_dmaio.sv
// Directed bench for dmaio: CPU register port driven by tasks, a registered
// ROM-like memory model on the initiator bus, and logs of DMA reads and writes.
module tb_dmaio;

    logic clk;
    logic rst;
    logic irq;
    logic hold;
    int   checks;
    int   errors;

    logic [15:0] rd_log[$];
    logic [15:0] wa_log[$];
    logic [7:0]  wd_log[$];

    dmaio_if bus();

    dmaio #(.HOLD_WAIT(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .irq  (irq),
        .hold (hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Registered-read memory model plus bus activity logs
    always @(posedge clk) begin
        bus.m_DI <= mem_byte(bus.m_AD);
        if (bus.m_own && bus.m_vma) begin
            if (bus.m_rw) begin
                rd_log.push_back(bus.m_AD);
            end else begin
                wa_log.push_back(bus.m_AD);
                wd_log.push_back(bus.m_DO);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.cs = 1'b1; bus.rw = 1'b0; bus.AD = a; bus.DI = d;
        @(negedge clk);
        bus.cs = 1'b0; bus.rw = 1'b1;
    endtask

    task automatic cpu_rd(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.cs = 1'b1; bus.rw = 1'b1; bus.AD = a;
        #1 d = bus.DO;
        @(negedge clk);
        bus.cs = 1'b0;
    endtask

    task automatic peek(input logic [2:0] a, output logic [7:0] d);
        bus.AD = a;
        #1 d = bus.DO;
    endtask

    task automatic peek16(input logic [2:0] a, output logic [15:0] v);
        logic [7:0] hi, lo;
        peek(a, hi);
        peek(a + 3'd1, lo);
        v = {hi, lo};
    endtask

    task automatic setup(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
        cpu_wr(3'd0, s[15:8]); cpu_wr(3'd1, s[7:0]);
        cpu_wr(3'd2, d[15:8]); cpu_wr(3'd3, d[7:0]);
        cpu_wr(3'd4, n[15:8]); cpu_wr(3'd5, n[7:0]);
    endtask

    // Counts cycles with hold high, noting when the bus is first owned
    task automatic run_xfer(input int lim, output int hold_n, output int first_own);
        hold_n = 0;
        first_own = -1;
        while (hold && hold_n < lim) begin
            if (bus.m_own && first_own < 0) first_own = hold_n;
            hold_n++;
            @(negedge clk);
        end
        check("xfer_timeout", {31'd0, hold}, 32'd0);
    endtask

    initial begin
        logic [7:0]  v8;
        logic [15:0] v16;
        int hn, fo, rb, wb, n;

        checks = 0; errors = 0;
        rst = 1'b1;
        bus.cs = 1'b0; bus.rw = 1'b1; bus.AD = 3'd0; bus.DI = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_hold", {31'd0, hold}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_own", {31'd0, bus.m_own}, 32'd0);
        check("rst_mad", {16'd0, bus.m_AD}, 32'h0);
        check("rst_mdo", {24'd0, bus.m_DO}, 32'h0);
        check("rst_mrw", {31'd0, bus.m_rw}, 32'd1);
        check("rst_vma", {31'd0, bus.m_vma}, 32'd0);
        peek(3'd7, v8); check("rst_status", {24'd0, v8}, 32'h0);

        // 4-byte ROM->RAM copy with IE
        rb = rd_log.size(); wb = wa_log.size();
        setup(16'hF000, 16'h0100, 16'd4);
        cpu_wr(3'd6, 8'h03);
        run_xfer(100, hn, fo);
        check("t1_hold_cycles", hn, 32'd14);
        check("t1_first_own", fo, 32'd2);
        check("t1_irq", {31'd0, irq}, 32'd1);
        peek16(3'd0, v16); check("t1_src", {16'd0, v16}, 32'hF004);
        peek16(3'd2, v16); check("t1_dst", {16'd0, v16}, 32'h0104);
        peek16(3'd4, v16); check("t1_cnt", {16'd0, v16}, 32'h0000);
        peek(3'd6, v8); check("t1_ctrl", {24'd0, v8}, 32'h02);
        check("t1_nwr", wa_log.size() - wb, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("t1_wa", {16'd0, wa_log[wb + i]}, {16'd0, 16'h0100 + 16'(i)});
            check("t1_wd", {24'd0, wd_log[wb + i]}, {24'd0, mem_byte(16'hF000 + 16'(i))});
            check("t1_ra", {16'd0, rd_log[rb + i]}, {16'd0, 16'hF000 + 16'(i)});
        end
        cpu_rd(3'd7, v8); check("t1_status", {24'd0, v8}, 32'h02);
        check("t1_irq_clr", {31'd0, irq}, 32'd0);
        peek(3'd7, v8); check("t1_status_clr", {24'd0, v8}, 32'h00);

        // Fixed source (UART data register)
        rb = rd_log.size(); wb = wa_log.size();
        setup(16'hE6A8, 16'h0200, 16'd3);
        cpu_wr(3'd6, 8'h05);
        run_xfer(100, hn, fo);
        check("t2_hold_cycles", hn, 32'd11);
        check("t2_irq", {31'd0, irq}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("t2_ra", {16'd0, rd_log[rb + i]}, 32'hE6A8);
            check("t2_wa", {16'd0, wa_log[wb + i]}, {16'd0, 16'h0200 + 16'(i)});
        end
        peek16(3'd0, v16); check("t2_src", {16'd0, v16}, 32'hE6A8);
        cpu_rd(3'd7, v8); check("t2_status", {24'd0, v8}, 32'h02);

        // Source wraps past $FFFF
        rb = rd_log.size(); wb = wa_log.size();
        setup(16'hFFFE, 16'h0010, 16'd3);
        cpu_wr(3'd6, 8'h01);
        run_xfer(100, hn, fo);
        check("t3_ra0", {16'd0, rd_log[rb]}, 32'hFFFE);
        check("t3_ra1", {16'd0, rd_log[rb + 1]}, 32'hFFFF);
        check("t3_ra2", {16'd0, rd_log[rb + 2]}, 32'h0000);
        check("t3_wd2", {24'd0, wd_log[wb + 2]}, {24'd0, mem_byte(16'h0000)});
        peek16(3'd0, v16); check("t3_src", {16'd0, v16}, 32'h0001);
        peek16(3'd2, v16); check("t3_dst", {16'd0, v16}, 32'h0013);
        cpu_rd(3'd7, v8);

        // START with CNT=0: immediate DONE, no hold
        cpu_wr(3'd6, 8'h01);
        check("t4_hold", {31'd0, hold}, 32'd0);
        peek(3'd7, v8); check("t4_status", {24'd0, v8}, 32'h02);
        @(negedge clk);
        check("t4_hold2", {31'd0, hold}, 32'd0);
        cpu_rd(3'd7, v8);

        // ABORT issued during the 5th WR cycle
        wb = wa_log.size();
        setup(16'h1000, 16'h2000, 16'd100);
        cpu_wr(3'd6, 8'h03);
        n = 0;
        for (int c = 0; c < 200 && n < 5; c++) begin
            if (bus.m_own && bus.m_vma && !bus.m_rw) n++;
            if (n < 5) @(negedge clk);
        end
        check("t5_saw_wr5", n, 32'd5);
        bus.cs = 1'b1; bus.rw = 1'b0; bus.AD = 3'd6; bus.DI = 8'h80;
        @(negedge clk);
        bus.cs = 1'b0; bus.rw = 1'b1;
        run_xfer(400, hn, fo);
        peek16(3'd4, v16); check("t5_cnt", {16'd0, v16}, 32'd95);
        check("t5_nwr", wa_log.size() - wb, 32'd5);
        check("t5_irq", {31'd0, irq}, 32'd1);
        cpu_rd(3'd7, v8); check("t5_status", {24'd0, v8}, 32'h06);

        // Reset during the 2nd RDW of a 4-byte copy
        wb = wa_log.size();
        setup(16'h3000, 16'h4000, 16'd4);
        cpu_wr(3'd6, 8'h03);
        n = 0;
        for (int c = 0; c < 100 && n < 2; c++) begin
            if (bus.m_own && !bus.m_vma) n++;
            if (n < 2) @(negedge clk);
        end
        check("t6_saw_rdw2", n, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_hold", {31'd0, hold}, 32'd0);
        check("t6_vma", {31'd0, bus.m_vma}, 32'd0);
        check("t6_own", {31'd0, bus.m_own}, 32'd0);
        for (int r = 0; r < 8; r++) begin
            peek(3'(r), v8);
            check("t6_reg", {24'd0, v8}, 32'h0);
        end
        repeat (6) @(negedge clk);
        check("t6_nwr", wa_log.size() - wb, 32'd1);
        check("t6_wa", {16'd0, wa_log[wb]}, 32'h4000);
        check("t6_wd", {24'd0, wd_log[wb]}, {24'd0, mem_byte(16'h3000)});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
